mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving SRAM access cycles; legal range 1..15.
REQ-002 Clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset, sampled on rising Clk.
REQ-004 Req_Rd  input  1  single-cycle read request from the datapath (MAR valid).
REQ-005 Req_Wr  input  1  single-cycle write request from the datapath (MAR and MDR valid).
REQ-006 Addr  input  16  word address from MAR.
REQ-007 Wdata  input  16  write data from MDR.
REQ-008 Rdata  output  16  registered read data, loaded into MDR when Ready=1.
REQ-009 Ready  output  1  one-cycle completion pulse.
REQ-010 Busy  output  1  high while an access is in progress.
REQ-011 CE, UB, LB, OE, WE  output  1 each  active-low SRAM controls.
REQ-012 ADDR  output  20  SRAM address, {4'b0, latched Addr}.
REQ-013 Data  inout  16  SRAM data bus, driven only during write states, else high-Z.

Function
REQ-014 States SHALL be IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE; a 4-bit wait counter is the only other sequencer state.
REQ-015 All SRAM control outputs, ADDR and Data drive SHALL be decoded from registered state only; no combinational path from Req_Rd/Req_Wr/Addr/Wdata to SRAM pins.
REQ-016 IDLE: CE=OE=WE=UB=LB=1, Data high-Z, Busy=0, Ready=0.
REQ-017 IDLE with Req_Rd=1: latch Addr, clear counter, go to RD.
REQ-018 IDLE with Req_Wr=1 and Req_Rd=0: latch Addr and Wdata, go to WR_SETUP.
REQ-019 Req_Rd and Req_Wr both high in IDLE: read SHALL win; the write is dropped, not queued.
REQ-020 Requests arriving in any state other than IDLE SHALL be ignored with no effect on the access in progress.
REQ-021 RD: CE=OE=UB=LB=0, WE=1, Data high-Z; stay WAIT_CYCLES cycles; on last cycle capture Data into Rdata and go to DONE.
REQ-022 WR_SETUP: one cycle, CE=UB=LB=0, OE=WE=1, Data driven with latched Wdata.
REQ-023 WR_PULSE: WE=0, other controls as WR_SETUP, Data driven; stay WAIT_CYCLES cycles.
REQ-024 WR_HOLD: one cycle, WE=1, CE=0, Data still driven; then DONE.
REQ-025 DONE: all controls deasserted, Data high-Z, Ready=1 for exactly this cycle; next state IDLE unconditionally.
REQ-026 Busy SHALL be 1 in RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-027 Latency (request sampled at edge 0): read Ready high in cycle WAIT_CYCLES+1; write Ready high in cycle WAIT_CYCLES+3.
REQ-028 Rdata SHALL hold its value until the next completed read; writes SHALL NOT alter Rdata.
REQ-029 Latched Addr/Wdata SHALL NOT change during an access regardless of input changes.
REQ-030 Counter wrap SHALL NOT occur; it is cleared on every state entry.

Reset
REQ-031 Reset=0 at a rising edge SHALL force IDLE, counter=0, Rdata=16'h0000, latched Addr/Wdata=0, Ready=0, Busy=0, all controls high, Data high-Z.
REQ-032 Reset mid-access SHALL abort it within one edge; no Ready pulse SHALL follow for the aborted access.
REQ-033 Reset SHALL take priority over any simultaneous request.

Verification (WAIT_CYCLES=2)
REQ-034 Read: memory[16'h0030]=16'hBEEF, Req_Rd with Addr=16'h0030 -> OE=0 cycles 1-2, Ready cycle 3, Rdata=16'hBEEF, ADDR=20'h00030.
REQ-035 Write: Req_Wr, Addr=16'h0042, Wdata=16'h1234 -> WE=0 cycles 2-3 only, Data=16'h1234 cycles 1-4, Ready cycle 5, memory[16'h0042]=16'h1234.
REQ-036 Collision: Req_Rd and Req_Wr same cycle -> read performed, no WE pulse, memory unchanged.
REQ-037 Busy ignore: second Req_Wr during RD cycle 1 -> single Ready pulse, no WE pulse.
REQ-038 Abort: Reset=0 during WR_PULSE -> next cycle WE=1, CE=1, Data high-Z, Busy=0, no Ready.
REQ-039 Back-to-back: read then write issued in the cycle after Ready -> both complete, Rdata unchanged by the write.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Datapath-side request/response bundle for the SRAM access controller.
// master: datapath (issues requests); slave: controller (returns data/status).
interface mem_access_ctrl_if;
    logic        req_rd;
    logic        req_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;

    modport master (
        output req_rd,
        output req_wr,
        output addr,
        output wdata,
        input  rdata,
        input  ready,
        input  busy
    );

    modport slave (
        input  req_rd,
        input  req_wr,
        input  addr,
        input  wdata,
        output rdata,
        output ready,
        output busy
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Asynchronous SRAM access sequencer between the datapath MAR/MDR and SRAM.
// Ports: clk_i, rst_ni (sync, active-low), bus (datapath slave side),
//   sram_*_n_o active-low SRAM strobes, sram_addr_o, sram_data_io (tristate).
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_access_ctrl_if.slave   bus,
    output logic               sram_ce_n_o,
    output logic               sram_ub_n_o,
    output logic               sram_lb_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic [19:0]        sram_addr_o,
    inout  wire  [15:0]        sram_data_io
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE
    } state_e;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        drive;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state. Requests are only looked at in IDLE; read beats write
    // and a simultaneous write is simply dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_rd) begin
                    addr_d  = bus.addr;
                    cnt_d   = 4'd0;
                    state_d = S_RD;
                end else if (bus.req_wr) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = 4'd0;
                    state_d = S_WR_SETUP;
                end
            end
            S_RD: begin
                if (cnt_q == LAST) begin
                    rdata_d = sram_data_io;
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_SETUP: begin
                cnt_d   = 4'd0;
                state_d = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (cnt_q == LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_HOLD: begin
                cnt_d   = 4'd0;
                state_d = S_DONE;
            end
            S_DONE: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin decode depends on registered state only, so no request input
    // can reach an SRAM pin combinationally.
    always_comb begin
        sram_ce_n_o = 1'b1;
        sram_ub_n_o = 1'b1;
        sram_lb_n_o = 1'b1;
        sram_oe_n_o = 1'b1;
        sram_we_n_o = 1'b1;
        drive       = 1'b0;
        bus.ready   = 1'b0;
        bus.busy    = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
            end
            S_RD: begin
                sram_ce_n_o = 1'b0;
                sram_ub_n_o = 1'b0;
                sram_lb_n_o = 1'b0;
                sram_oe_n_o = 1'b0;
            end
            S_WR_SETUP: begin
                sram_ce_n_o = 1'b0;
                sram_ub_n_o = 1'b0;
                sram_lb_n_o = 1'b0;
                drive       = 1'b1;
            end
            S_WR_PULSE: begin
                sram_ce_n_o = 1'b0;
                sram_ub_n_o = 1'b0;
                sram_lb_n_o = 1'b0;
                sram_we_n_o = 1'b0;
                drive       = 1'b1;
            end
            S_WR_HOLD: begin
                sram_ce_n_o = 1'b0;
                sram_ub_n_o = 1'b0;
                sram_lb_n_o = 1'b0;
                drive       = 1'b1;
            end
            S_DONE: begin
                bus.ready = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    assign sram_addr_o  = {4'b0000, addr_q};
    assign sram_data_io = drive ? wdata_q : 16'hzzzz;
    assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed accesses against a small SRAM model,
// with a ready-driven scoreboard checking latency and read data.
module tb_mem_access_ctrl;

    localparam int W = 2;

    typedef struct {
        int          exp_cyc;
        logic [15:0] exp_rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ce_n, ub_n, lb_n, oe_n, we_n;
    logic [19:0] sram_addr;
    wire  [15:0] sram_data;

    logic [15:0] mem [0:255];
    exp_t        sb[$];
    int          cyc;
    int          we_lows;
    int          total;
    int          bad;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .WAIT_CYCLES(W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bus          (bus),
        .sram_ce_n_o  (ce_n),
        .sram_ub_n_o  (ub_n),
        .sram_lb_n_o  (lb_n),
        .sram_oe_n_o  (oe_n),
        .sram_we_n_o  (we_n),
        .sram_addr_o  (sram_addr),
        .sram_data_io (sram_data)
    );

    // SRAM model: drives the bus on an output-enabled read, stores on write.
    assign sram_data = (!ce_n && !oe_n && we_n) ?
                       mem[sram_addr[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n)
            mem[sram_addr[7:0]] <= sram_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial we_lows = 0;
    always @(negedge clk) begin
        if (!we_n)
            we_lows = we_lows + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every Ready pulse must match a pending access.
    always @(negedge clk) begin
        if (bus.ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("ready_cycle", 32'(cyc), 32'(x.exp_cyc));
                chk("rdata", {16'h0, bus.rdata}, {16'h0, x.exp_rdata});
                chk("busy_at_ready", {31'h0, bus.busy}, 32'h1);
            end
        end
    end

    // Issue one access at the current negedge and walk its pin timeline.
    task automatic op(input bit rd, input bit wr, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] exp_rdata);
        int e;
        int n;
        bit isrd;
        isrd       = rd;
        bus.req_rd = rd;
        bus.req_wr = wr;
        bus.addr   = a;
        bus.wdata  = wd;
        e = cyc + 1;
        sb.push_back('{isrd ? e + W : e + W + 2, exp_rdata});
        @(negedge clk);
        bus.req_rd = 1'b0;
        bus.req_wr = 1'b0;
        bus.addr   = ~a;
        bus.wdata  = ~wd;
        n = isrd ? W + 1 : W + 3;
        for (int k = 0; k < n; k++) begin
            if (k == 0)
                chk("addr_latched", {12'h0, sram_addr}, {16'h0, a});
            if (isrd) begin
                if (k < W) begin
                    chk("rd_ce", {31'h0, ce_n}, 32'h0);
                    chk("rd_oe", {31'h0, oe_n}, 32'h0);
                    chk("rd_we", {31'h0, we_n}, 32'h1);
                end else begin
                    chk("done_oe", {31'h0, oe_n}, 32'h1);
                    chk("done_ce", {31'h0, ce_n}, 32'h1);
                end
            end else begin
                if (k <= W + 1)
                    chk("wr_data", {16'h0, sram_data}, {16'h0, wd});
                if (k >= 1 && k <= W)
                    chk("wr_we_low", {31'h0, we_n}, 32'h0);
                else
                    chk("wr_we_high", {31'h0, we_n}, 32'h1);
                if (k <= W + 1) begin
                    chk("wr_ce", {31'h0, ce_n}, 32'h0);
                    chk("wr_oe", {31'h0, oe_n}, 32'h1);
                end else begin
                    chk("wr_done_ce", {31'h0, ce_n}, 32'h1);
                end
            end
            chk("busy_in_access", {31'h0, bus.busy}, 32'h1);
            @(negedge clk);
        end
        chk("idle_busy", {31'h0, bus.busy}, 32'h0);
    endtask

    initial begin
        int e;
        int wl;
        int t;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++)
            mem[i] = 16'(i * 3);
        mem[8'h30] = 16'hBEEF;

        // Reset with both requests active: reset must win.
        rst_n      = 1'b0;
        bus.req_rd = 1'b1;
        bus.req_wr = 1'b1;
        bus.addr   = 16'h1234;
        bus.wdata  = 16'h5678;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_ready", {31'h0, bus.ready}, 32'h0);
        chk("rst_rdata", {16'h0, bus.rdata}, 32'h0);
        chk("rst_addr", {12'h0, sram_addr}, 32'h0);
        chk("rst_ctrl", {27'h0, ce_n, ub_n, lb_n, oe_n, we_n}, 32'h1F);
        bus.req_rd = 1'b0;
        bus.req_wr = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);

        // Basic read and write.
        op(1'b1, 1'b0, 16'h0030, 16'h0000, 16'hBEEF);
        op(1'b0, 1'b1, 16'h0042, 16'h1234, 16'hBEEF);
        chk("mem_42", {16'h0, mem[8'h42]}, 32'h1234);
        op(1'b1, 1'b0, 16'h0042, 16'h0000, 16'h1234);

        // Collision: read wins, no WE pulse, memory untouched.
        wl = we_lows;
        op(1'b1, 1'b1, 16'h0030, 16'h5555, 16'hBEEF);
        chk("coll_no_we", 32'(we_lows - wl), 32'h0);
        chk("coll_mem", {16'h0, mem[8'h30]}, 32'hBEEF);

        // Write request during RD cycle 1 is ignored.
        wl = we_lows;
        bus.req_rd = 1'b1;
        bus.addr   = 16'h0042;
        e = cyc + 1;
        sb.push_back('{e + W, 16'h1234});
        @(negedge clk);
        bus.req_rd = 1'b0;
        bus.req_wr = 1'b1;
        bus.addr   = 16'h0099;
        bus.wdata  = 16'h0000;
        chk("ign_oe", {31'h0, oe_n}, 32'h0);
        @(negedge clk);
        bus.req_wr = 1'b0;
        chk("ign_addr", {12'h0, sram_addr}, 32'h42);
        t = 0;
        while (bus.busy === 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ign_timeout", 32'(t < 20), 32'h1);
        repeat (4) @(negedge clk);
        chk("ign_no_we", 32'(we_lows - wl), 32'h0);
        chk("ign_mem_30", {16'h0, mem[8'h30]}, 32'hBEEF);

        // Back-to-back: write issued the cycle after the read's Ready.
        op(1'b1, 1'b0, 16'h0030, 16'h0000, 16'hBEEF);
        op(1'b0, 1'b1, 16'h0050, 16'hABCD, 16'hBEEF);
        chk("b2b_mem", {16'h0, mem[8'h50]}, 32'hABCD);

        // Abort a write in WR_PULSE.
        bus.req_wr = 1'b1;
        bus.addr   = 16'h0060;
        bus.wdata  = 16'h7777;
        @(negedge clk);
        bus.req_wr = 1'b0;
        @(negedge clk);
        chk("abort_pulse", {31'h0, we_n}, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_we", {31'h0, we_n}, 32'h1);
        chk("abort_ce", {31'h0, ce_n}, 32'h1);
        chk("abort_busy", {31'h0, bus.busy}, 32'h0);
        chk("abort_ready", {31'h0, bus.ready}, 32'h0);
        chk("abort_rdata", {16'h0, bus.rdata}, 32'h0);
        chk("abort_addr", {12'h0, sram_addr}, 32'h0);
        repeat (8) @(negedge clk);

        // Still functional after the abort.
        op(1'b1, 1'b0, 16'h0050, 16'h0000, 16'hABCD);
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
